pixel_compositor: RTL and testbench
===================================

// Module: pixel_compositor
// PURPOSE
//  Final pixel stage of the VGA output path. Overlays NUM_LAYERS priority-ordered
//  overlay layers (text, graphics, crosshairs, ...) on the processed video pixel.
//  Supports per-layer transparency keying and optional 50% blend, a BRAM readback
//  mode and a force-black mode. Delays hsync/vsync/blank by SYNC_DLY so they line
//  up with the video pipeline. Layer configuration is frame-synchronous, so
//  mid-frame switch changes never tear.
// PARAMETERS
//  NUM_LAYERS  4          number of overlay layers; layer 0 has highest priority
//  PIX_W       24         pixel width, 8b R/G/B, R in MSBs
//  SYNC_DLY    44         total sync/blank delay in cycles; must be >= 2
//  KEY_COLOR   24'h000000 layer pixel value treated as transparent
// PORTS
//  clk         in   1                   pixel clock
//  reset       in   1                   synchronous, active-high reset
//  hsync       in   1                   raw VGA hsync, active low
//  vsync       in   1                   raw VGA vsync, active low
//  blank       in   1                   raw VGA blank
//  base_pix    in   PIX_W               processed video pixel, valid SYNC_DLY-2 cycles after its sync
//  layer_pix   in   NUM_LAYERS*PIX_W    overlay pixels; layer i at [i*PIX_W +: PIX_W], aligned with base_pix
//  layer_en    in   NUM_LAYERS          per-layer enable (config, latched per frame)
//  layer_blend in   NUM_LAYERS          1 = 50% blend with base_pix; 0 = opaque (latched per frame)
//  readback_en in   1                   show BRAM frame instead of the composite
//  in_display  in   1                   readback pixel lies inside the stored frame window
//  bram_dout   in   8                   stored RGB332 pixel
//  force_black in   1                   drive black (e.g. while sending the frame to the PC)
//  pixel_out   out  PIX_W               composited pixel
//  hsync_out   out  1                   hsync delayed by SYNC_DLY
//  vsync_out   out  1                   vsync delayed by SYNC_DLY
//  blank_out   out  1                   blank delayed by SYNC_DLY
// BEHAVIOUR
//  Reset
//   - pixel_out = 0.
//   - All sync/blank shift-register stages = 1. Outputs therefore read hsync_out=1,
//     vsync_out=1, blank_out=1 until the pipeline refills (SYNC_DLY cycles).
//   - Latched en/blend = 0.
//  Config latch
//   - en_q <= layer_en and blend_q <= layer_blend on the cycle the registered vsync
//     falls (vsync_d=1, vsync=0).
//   - Values hold for the whole frame. A change mid-frame takes effect only at the
//     next vsync fall.
//   - Reset mid-frame clears en_q/blend_q immediately.
//  Stage 1 (registered): select
//   - Pick the lowest index i with en_q[i]=1 and layer_pix[i] != KEY_COLOR. Register
//     hit, sel_pix, sel_blend and base_pix.
//   - No hit: the base pixel passes through.
//  Stage 2 (registered): mode mux, evaluated in priority order (first match wins)
//   1. force_black  -> 0.
//   2. readback_en  -> in_display ? {d[7:5],5'b0, d[4:2],5'b0, d[1:0],6'b0} : 24'hFFFFFF.
//   3. hit & sel_blend -> per channel (sel + base) >> 1, using a 9-bit sum, no rounding.
//   4. hit          -> sel_pix.
//   5. otherwise    -> base.
//  Timing of the stage-2 controls
//   - force_black, readback_en, in_display and bram_dout are sampled un-delayed in
//     stage 2; the BRAM address path must account for this.
//   - Composite latency is 2 cycles: base_pix/layer_pix at cycle t appear at
//     pixel_out at t+2.
//  Sync path
//   - Each of hsync/vsync/blank passes through a SYNC_DLY-deep shift register.
//   - Output = last stage. Exact delay is SYNC_DLY cycles.
//  Boundary conditions
//   - All layers disabled -> pure passthrough.
//   - A layer pixel equal to KEY_COLOR is never drawn, even when enabled.
//   - Blend with a keyed layer falls through to the next layer; the blend is never
//     applied to a transparent pixel.
//   - Simultaneous force_black and readback_en: force_black wins.
// TESTING
//  1. Reset: assert reset 3 cycles -> pixel_out=0, sync/blank outs=1; release and
//     drive hsync=0 at t0 -> hsync_out=0 exactly at t0+SYNC_DLY.
//  2. Priority: en=4'b0011 latched, layer0=24'h00FF00, layer1=24'hFF0000,
//     base=24'h123456 -> pixel_out=24'h00FF00 2 cycles later; layer0=KEY_COLOR ->
//     24'hFF0000.
//  3. Blend: en=4'b0001, blend=4'b0001, layer0=24'hFF0000, base=24'h0000FF ->
//     pixel_out=24'h7F007F.
//  4. Frame latch: set layer_en=4'b0001 mid-frame -> output stays base until the
//     vsync falling edge, then shows layer 0.
//  5. Readback: readback_en=1, in_display=1, bram_dout=8'b111_000_11 ->
//     24'hE000C0; in_display=0 -> 24'hFFFFFF.
//  6. Force black: force_black=1 together with readback_en=1 and an active layer ->
//     pixel_out=0; deassert -> normal output 1 cycle later.

Source files
------------

// File: rtl/pixel_compositor.sv
// Final VGA pixel stage: priority overlay compositing with keying/blend, BRAM readback,
// force-black, and a matching delay line for hsync/vsync/blank.
module pixel_compositor #(
  parameter int                NUM_LAYERS = 4,
  parameter int                PIX_W      = 24,
  parameter int                SYNC_DLY   = 44,
  parameter logic [PIX_W-1:0]  KEY_COLOR  = 24'h000000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        hsync,
  input  logic                        vsync,
  input  logic                        blank,
  input  logic [PIX_W-1:0]            base_pix,
  input  logic [NUM_LAYERS*PIX_W-1:0] layer_pix,
  input  logic [NUM_LAYERS-1:0]       layer_en,
  input  logic [NUM_LAYERS-1:0]       layer_blend,
  input  logic                        readback_en,
  input  logic                        in_display,
  input  logic [7:0]                  bram_dout,
  input  logic                        force_black,
  output logic [PIX_W-1:0]            pixel_out,
  output logic                        hsync_out,
  output logic                        vsync_out,
  output logic                        blank_out
);

  localparam int CH_W = PIX_W / 3;

  // Sync/blank delay lines; stage 0 of the vsync line doubles as the edge detector.
  logic [SYNC_DLY-1:0] r_hsync_sr;
  logic [SYNC_DLY-1:0] r_vsync_sr;
  logic [SYNC_DLY-1:0] r_blank_sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hsync_sr <= '1;
      r_vsync_sr <= '1;
      r_blank_sr <= '1;
    end else begin
      r_hsync_sr <= {r_hsync_sr[SYNC_DLY-2:0], hsync};
      r_vsync_sr <= {r_vsync_sr[SYNC_DLY-2:0], vsync};
      r_blank_sr <= {r_blank_sr[SYNC_DLY-2:0], blank};
    end
  end

  assign hsync_out = r_hsync_sr[SYNC_DLY-1];
  assign vsync_out = r_vsync_sr[SYNC_DLY-1];
  assign blank_out = r_blank_sr[SYNC_DLY-1];

  logic w_vsync_fall;
  assign w_vsync_fall = r_vsync_sr[0] & ~vsync;

  // Layer config is only sampled at frame start so switch changes never tear a frame.
  logic [NUM_LAYERS-1:0] r_en_q;
  logic [NUM_LAYERS-1:0] r_blend_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_en_q    <= '0;
      r_blend_q <= '0;
    end else if (w_vsync_fall) begin
      r_en_q    <= layer_en;
      r_blend_q <= layer_blend;
    end
  end

  logic [NUM_LAYERS-1:0] w_layer_vis;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_vis
      assign w_layer_vis[gi] = r_en_q[gi] &&
                               (layer_pix[gi*PIX_W +: PIX_W] != KEY_COLOR);
    end
  endgenerate

  logic             w_hit;
  logic [PIX_W-1:0] w_sel_pix;
  logic             w_sel_blend;

  // Walk from the lowest priority upward so the lowest visible index wins.
  always_comb begin
    w_hit       = 1'b0;
    w_sel_pix   = '0;
    w_sel_blend = 1'b0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (w_layer_vis[i]) begin
        w_hit       = 1'b1;
        w_sel_pix   = layer_pix[i*PIX_W +: PIX_W];
        w_sel_blend = r_blend_q[i];
      end
    end
  end

  logic             r_hit;
  logic             r_sel_blend;
  logic [PIX_W-1:0] r_sel_pix;
  logic [PIX_W-1:0] r_base_pix;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit       <= 1'b0;
      r_sel_blend <= 1'b0;
      r_sel_pix   <= '0;
      r_base_pix  <= '0;
    end else begin
      r_hit       <= w_hit;
      r_sel_blend <= w_sel_blend;
      r_sel_pix   <= w_sel_pix;
      r_base_pix  <= base_pix;
    end
  end

  logic [PIX_W-1:0] w_blend_pix;

  generate
    for (gi = 0; gi < 3; gi++) begin : g_blend
      logic [CH_W:0] w_sum;
      assign w_sum = {1'b0, r_sel_pix[gi*CH_W +: CH_W]} +
                     {1'b0, r_base_pix[gi*CH_W +: CH_W]};
      assign w_blend_pix[gi*CH_W +: CH_W] = w_sum[CH_W:1];
    end
  endgenerate

  // RGB332 expanded by zero-filling the low bits of each channel.
  logic [PIX_W-1:0] w_rb_pix;
  assign w_rb_pix = {bram_dout[7:5], 5'b0, bram_dout[4:2], 5'b0, bram_dout[1:0], 6'b0};

  logic [PIX_W-1:0] r_pixel;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pixel <= '0;
    end else if (force_black) begin
      r_pixel <= '0;
    end else if (readback_en) begin
      r_pixel <= in_display ? w_rb_pix : '1;
    end else if (r_hit && r_sel_blend) begin
      r_pixel <= w_blend_pix;
    end else if (r_hit) begin
      r_pixel <= r_sel_pix;
    end else begin
      r_pixel <= r_base_pix;
    end
  end

  assign pixel_out = r_pixel;

endmodule

// File: tb/tb_pixel_compositor.sv
// Directed checks of pixel_compositor: reset, sync delay, priority, keying, blend,
// frame-synchronous config, readback and force-black.
module tb_pixel_compositor;

  localparam int NL  = 4;
  localparam int PW  = 24;
  localparam int DLY = 44;

  logic           clk = 1'b0;
  logic           reset;
  logic           hsync, vsync, blank;
  logic [PW-1:0]  base_pix;
  logic [NL*PW-1:0] layer_pix;
  logic [NL-1:0]  layer_en, layer_blend;
  logic           readback_en, in_display, force_black;
  logic [7:0]     bram_dout;
  logic [PW-1:0]  pixel_out;
  logic           hsync_out, vsync_out, blank_out;

  int n_checks = 0;
  int n_fail   = 0;

  pixel_compositor #(
    .NUM_LAYERS(NL), .PIX_W(PW), .SYNC_DLY(DLY), .KEY_COLOR(24'h000000)
  ) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .blank(blank),
    .base_pix(base_pix), .layer_pix(layer_pix), .layer_en(layer_en),
    .layer_blend(layer_blend), .readback_en(readback_en), .in_display(in_display),
    .bram_dout(bram_dout), .force_black(force_black), .pixel_out(pixel_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_out(blank_out)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic latch_config(input logic [NL-1:0] en, input logic [NL-1:0] bl);
    layer_en = en; layer_blend = bl;
    vsync = 1'b1; step(1);
    vsync = 1'b0; step(1);
    vsync = 1'b1; step(1);
  endtask

  task automatic test_reset;
    reset = 1'b1; hsync = 1'b0; vsync = 1'b1; blank = 1'b0;
    base_pix = 24'h123456; layer_pix = {4{24'h445566}};
    layer_en = '1; layer_blend = '0;
    readback_en = 1'b0; in_display = 1'b0; bram_dout = 8'h00; force_black = 1'b0;
    step(3);
    n_checks++;
    if (pixel_out !== 24'h000000) begin
      n_fail++; $display("FAIL reset_pixel: got %h want %h", pixel_out, 24'h000000);
    end else $display("ok reset_pixel %h", pixel_out);
    n_checks++;
    if ({hsync_out, vsync_out, blank_out} !== 3'b111) begin
      n_fail++; $display("FAIL reset_sync: got %b want 111", {hsync_out, vsync_out, blank_out});
    end else $display("ok reset_sync");
    // t0: hsync low for one cycle, blank held low from release.
    reset = 1'b0; hsync = 1'b0;
    step(1);
    hsync = 1'b1;
    step(DLY - 2);
    n_checks++;
    if ({hsync_out, blank_out} !== 2'b11) begin
      n_fail++; $display("FAIL sync_early: got %b want 11", {hsync_out, blank_out});
    end else $display("ok sync_early");
    step(1);
    n_checks++;
    if ({hsync_out, blank_out} !== 2'b00) begin
      n_fail++; $display("FAIL sync_exact: got %b want 00", {hsync_out, blank_out});
    end else $display("ok sync_exact");
    step(1);
    n_checks++;
    if ({hsync_out, blank_out} !== 2'b10) begin
      n_fail++; $display("FAIL sync_after: got %b want 10", {hsync_out, blank_out});
    end else $display("ok sync_after");
    n_checks++;
    if (pixel_out !== 24'h123456) begin
      n_fail++; $display("FAIL reset_passthru: got %h want %h", pixel_out, 24'h123456);
    end else $display("ok reset_passthru %h", pixel_out);
  endtask

  task automatic test_priority;
    layer_pix = {24'h0, 24'h0, 24'hFF0000, 24'h00FF00};
    base_pix  = 24'h123456;
    latch_config(4'b0011, 4'b0000);
    step(2);
    n_checks++;
    if (pixel_out !== 24'h00FF00) begin
      n_fail++; $display("FAIL prio_l0: got %h want %h", pixel_out, 24'h00FF00);
    end else $display("ok prio_l0 %h", pixel_out);
    layer_pix[23:0] = 24'h000000;
    step(2);
    n_checks++;
    if (pixel_out !== 24'hFF0000) begin
      n_fail++; $display("FAIL prio_key_l1: got %h want %h", pixel_out, 24'hFF0000);
    end else $display("ok prio_key_l1 %h", pixel_out);
    layer_pix = {24'h0, 24'h0, 24'h0, 24'h0};
    step(2);
    n_checks++;
    if (pixel_out !== 24'h123456) begin
      n_fail++; $display("FAIL prio_all_keyed: got %h want %h", pixel_out, 24'h123456);
    end else $display("ok prio_all_keyed %h", pixel_out);
    layer_pix = {24'h0, 24'h0, 24'hFF0000, 24'h00FF00};
    latch_config(4'b0000, 4'b0000);
    step(2);
    n_checks++;
    if (pixel_out !== 24'h123456) begin
      n_fail++; $display("FAIL prio_disabled: got %h want %h", pixel_out, 24'h123456);
    end else $display("ok prio_disabled %h", pixel_out);
  endtask

  task automatic test_blend;
    layer_pix = {24'h0, 24'h0, 24'h0, 24'hFF0000};
    base_pix  = 24'h0000FF;
    latch_config(4'b0001, 4'b0001);
    step(2);
    n_checks++;
    if (pixel_out !== 24'h7F007F) begin
      n_fail++; $display("FAIL blend_basic: got %h want %h", pixel_out, 24'h7F007F);
    end else $display("ok blend_basic %h", pixel_out);
    layer_pix[23:0] = 24'hFFFFFF; base_pix = 24'hFFFF01;
    step(2);
    n_checks++;
    if (pixel_out !== 24'hFFFF80) begin
      n_fail++; $display("FAIL blend_carry: got %h want %h", pixel_out, 24'hFFFF80);
    end else $display("ok blend_carry %h", pixel_out);
    // Keyed blending layer 0 falls through to opaque layer 1.
    layer_pix = {24'h0, 24'h0, 24'h112233, 24'h000000};
    base_pix  = 24'h0000FF;
    latch_config(4'b0011, 4'b0001);
    step(2);
    n_checks++;
    if (pixel_out !== 24'h112233) begin
      n_fail++; $display("FAIL blend_keyed: got %h want %h", pixel_out, 24'h112233);
    end else $display("ok blend_keyed %h", pixel_out);
  endtask

  task automatic test_frame_latch;
    layer_pix = {24'h0, 24'h0, 24'h0, 24'hABCDEF};
    base_pix  = 24'h123456;
    latch_config(4'b0000, 4'b0000);
    layer_en = 4'b0001;
    step(4);
    n_checks++;
    if (pixel_out !== 24'h123456) begin
      n_fail++; $display("FAIL latch_midframe: got %h want %h", pixel_out, 24'h123456);
    end else $display("ok latch_midframe %h", pixel_out);
    vsync = 1'b0; step(1);
    vsync = 1'b1; step(1);
    n_checks++;
    if (pixel_out !== 24'h123456) begin
      n_fail++; $display("FAIL latch_edge_plus1: got %h want %h", pixel_out, 24'h123456);
    end else $display("ok latch_edge_plus1 %h", pixel_out);
    step(1);
    n_checks++;
    if (pixel_out !== 24'hABCDEF) begin
      n_fail++; $display("FAIL latch_edge_plus2: got %h want %h", pixel_out, 24'hABCDEF);
    end else $display("ok latch_edge_plus2 %h", pixel_out);
  endtask

  task automatic test_reset_mid_frame;
    reset = 1'b1; step(1);
    reset = 1'b0; step(2);
    n_checks++;
    if (pixel_out !== 24'h123456) begin
      n_fail++; $display("FAIL reset_clears_cfg: got %h want %h", pixel_out, 24'h123456);
    end else $display("ok reset_clears_cfg %h", pixel_out);
  endtask

  task automatic test_readback;
    readback_en = 1'b1; in_display = 1'b1; bram_dout = 8'b111_000_11;
    step(1);
    n_checks++;
    if (pixel_out !== 24'hE000C0) begin
      n_fail++; $display("FAIL rb_inside: got %h want %h", pixel_out, 24'hE000C0);
    end else $display("ok rb_inside %h", pixel_out);
    bram_dout = 8'b010_101_10;
    step(1);
    n_checks++;
    if (pixel_out !== 24'h40A080) begin
      n_fail++; $display("FAIL rb_mixed: got %h want %h", pixel_out, 24'h40A080);
    end else $display("ok rb_mixed %h", pixel_out);
    in_display = 1'b0;
    step(1);
    n_checks++;
    if (pixel_out !== 24'hFFFFFF) begin
      n_fail++; $display("FAIL rb_outside: got %h want %h", pixel_out, 24'hFFFFFF);
    end else $display("ok rb_outside %h", pixel_out);
    readback_en = 1'b0;
  endtask

  task automatic test_force_black;
    layer_pix = {24'h0, 24'h0, 24'h0, 24'hABCDEF};
    base_pix  = 24'h123456;
    latch_config(4'b0001, 4'b0000);
    step(2);
    n_checks++;
    if (pixel_out !== 24'hABCDEF) begin
      n_fail++; $display("FAIL fb_pre: got %h want %h", pixel_out, 24'hABCDEF);
    end else $display("ok fb_pre %h", pixel_out);
    force_black = 1'b1; readback_en = 1'b1; in_display = 1'b1; bram_dout = 8'b111_000_11;
    step(1);
    n_checks++;
    if (pixel_out !== 24'h000000) begin
      n_fail++; $display("FAIL fb_wins: got %h want %h", pixel_out, 24'h000000);
    end else $display("ok fb_wins %h", pixel_out);
    force_black = 1'b0;
    step(1);
    n_checks++;
    if (pixel_out !== 24'hE000C0) begin
      n_fail++; $display("FAIL fb_release_rb: got %h want %h", pixel_out, 24'hE000C0);
    end else $display("ok fb_release_rb %h", pixel_out);
    readback_en = 1'b0;
    step(1);
    n_checks++;
    if (pixel_out !== 24'hABCDEF) begin
      n_fail++; $display("FAIL fb_release_layer: got %h want %h", pixel_out, 24'hABCDEF);
    end else $display("ok fb_release_layer %h", pixel_out);
  endtask

  initial begin
    test_reset;
    test_priority;
    test_blend;
    test_frame_latch;
    test_reset_mid_frame;
    test_readback;
    test_force_black;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
